// File: rtl/aes_128_dec.sv
// Iterative AES-128 inverse cipher: expands the key forward to round key 10,
// then walks the schedule backwards one round per cycle while decrypting.
package aes_128_dec_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 for free.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction
endpackage

module aes_sbox import aes_128_dec_pkg::*; (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] b;
  assign b   = gf_inv(a_i);
  assign y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox import aes_128_dec_pkg::*; (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] b;
  assign b   = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
  assign y_o = gf_inv(b);
endmodule

module aes_128_dec import aes_128_dec_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         ready,
  output logic         done,
  output logic [127:0] out
);
  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] s_q, s_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_q, out_d;
  logic         done_q, done_d;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Forward and inverse key steps both feed one word through SubWord(RotWord()),
  // so a single set of four S-boxes serves both directions.
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, sw_rot, sw_out, rcon_w;
  logic [31:0] f0, f1, f2, f3;
  logic [127:0] rk_fwd, rk_inv;

  assign {w0, w1, w2, w3} = rk_q;
  assign sw_in  = (fsm_q == KEXP) ? w3 : (w3 ^ w2);
  assign sw_rot = {sw_in[23:0], sw_in[31:24]};
  assign rcon_w = {rcon(cnt_q), 24'h000000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw
      aes_sbox u_sbox (.a_i(sw_rot[8*gi +: 8]), .y_o(sw_out[8*gi +: 8]));
    end
  endgenerate

  assign f0     = w0 ^ sw_out ^ rcon_w;
  assign f1     = w1 ^ f0;
  assign f2     = w2 ^ f1;
  assign f3     = w3 ^ f2;
  assign rk_fwd = {f0, f1, f2, f3};
  assign rk_inv = {w0 ^ sw_out ^ rcon_w, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // Byte i sits at row i%4, column i/4; byte 0 is the MSB of the block.
  logic [127:0] isb, ark, imc;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = R + 4 * ((C - R + 4) % 4);
      aes_inv_sbox u_isbox (.a_i(s_q[127-8*SRC -: 8]), .y_o(isb[127-8*gi -: 8]));
    end
  endgenerate

  assign ark = isb ^ rk_q;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ark[127-32*gi -: 8];
      assign a1 = ark[119-32*gi -: 8];
      assign a2 = ark[111-32*gi -: 8];
      assign a3 = ark[103-32*gi -: 8];
      assign imc[127-32*gi -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
  endgenerate

  // cnt_q counts up through KEXP, then down from 9 so it doubles as the
  // reverse rcon index during INIT and ROUND.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    s_d    = s_q;
    rk_d   = rk_q;
    out_d  = out_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          s_d   = state;
          rk_d  = key;
          cnt_d = 4'd0;
          fsm_d = KEXP;
        end
      end
      KEXP: begin
        rk_d = rk_fwd;
        if (cnt_q == 4'd9) fsm_d = INIT;
        else               cnt_d = cnt_q + 4'd1;
      end
      INIT: begin
        s_d   = s_q ^ rk_q;
        rk_d  = rk_inv;
        cnt_d = cnt_q - 4'd1;
        fsm_d = ROUND;
      end
      ROUND: begin
        s_d  = imc;
        rk_d = rk_inv;
        if (cnt_q == 4'd0) fsm_d = FINAL;
        else               cnt_d = cnt_q - 4'd1;
      end
      FINAL: begin
        out_d  = ark;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= 4'd0;
      s_q    <= '0;
      rk_q   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      s_q    <= s_d;
      rk_q   <= rk_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign ready = (fsm_q == IDLE);
  assign done  = done_q;
  assign out   = out_q;
endmodule

// File: tb/tb_aes_128_dec.sv
// Bench for aes_128_dec: known-answer vectors plus random blocks encrypted by
// a table-driven AES-128 model and checked to decrypt back to the plaintext.
module tb_aes_128_dec;
  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] state;
  logic [127:0] key;
  logic         ready;
  logic         done;
  logic [127:0] out;

  int tests_run;
  int tests_failed;

  aes_128_dec dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .key(key),
    .ready(ready), .done(done), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (log/antilog tables) ----------------
  logic [7:0] exp_t [255];
  int         log_t [256];
  logic [7:0] sb_t  [256];
  logic [31:0] ks   [44];
  logic [7:0] ms    [16];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] x, inv, s, c;
    c = 8'h63;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : exp_t[(255 - log_t[a]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb_t[a] = s;
    end
  endtask

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) ks[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = ks[i-1];
      if (i % 4 == 0) begin
        t = {sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]], sb_t[t[31:24]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      ks[i] = ks[i-4] ^ t;
    end
  endtask

  task automatic m_add(input int r);
    for (int i = 0; i < 16; i++) ms[i] = ms[i] ^ ks[4*r + i/4][31-8*(i%4) -: 8];
  endtask

  task automatic m_sub();
    for (int i = 0; i < 16; i++) ms[i] = sb_t[ms[i]];
  endtask

  task automatic m_shift();
    logic [7:0] tmp [16];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) tmp[r + 4*c] = ms[r + 4*((c + r) % 4)];
    for (int i = 0; i < 16; i++) ms[i] = tmp[i];
  endtask

  task automatic m_mix();
    logic [7:0] a [4];
    logic [7:0] coef [4];
    logic [7:0] acc;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = ms[4*c + j];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], a[j]);
        ms[4*c + r] = acc;
      end
    end
  endtask

  task automatic model_encrypt(input logic [127:0] pt, input logic [127:0] k,
                               output logic [127:0] ct);
    expand_key(k);
    for (int i = 0; i < 16; i++) ms[i] = pt[127-8*i -: 8];
    m_add(0);
    for (int r = 1; r < 10; r++) begin
      m_sub(); m_shift(); m_mix(); m_add(r);
    end
    m_sub(); m_shift(); m_add(10);
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = ms[i];
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- DUT drivers ----------------
  task automatic wait_done(input int lat0, output logic [127:0] res, output int lat);
    lat = lat0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 60);
    res = out;
  endtask

  task automatic launch(input logic [127:0] ct, input logic [127:0] k);
    @(negedge clk);
    state = ct;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_op(input logic [127:0] ct, input logic [127:0] k,
                       output logic [127:0] res, output int lat);
    launch(ct, k);
    wait_done(0, res, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", ready); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++;
    if (out !== 128'h0) begin tests_failed++; $display("FAIL reset_out: got %h expected 0", out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_kat_c1();
    logic [127:0] res;
    int lat;
    do_op(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f, res, lat);
    tests_run++;
    if (lat !== 21) begin tests_failed++; $display("FAIL c1_latency: got %0d expected 21", lat); end
    tests_run++;
    if (res !== 128'h00112233445566778899aabbccddeeff) begin
      tests_failed++; $display("FAIL c1_out: got %h expected 00112233445566778899aabbccddeeff", res);
    end
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL c1_ready_with_done: got %b expected 1", ready); end
    $display("[TB] C.1 out=%h latency=%0d", res, lat);
  endtask

  task automatic test_kat_b();
    logic [127:0] res;
    int lat;
    launch(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL b_busy_ready: got %b expected 0", ready); end
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (dut.rk_q !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      tests_failed++; $display("FAIL b_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", dut.rk_q);
    end
    wait_done(10, res, lat);
    tests_run++;
    if (lat !== 21) begin tests_failed++; $display("FAIL b_latency: got %0d expected 21", lat); end
    tests_run++;
    if (res !== 128'h3243f6a8885a308d313198a2e0370734) begin
      tests_failed++; $display("FAIL b_out: got %h expected 3243f6a8885a308d313198a2e0370734", res);
    end
    $display("[TB] B out=%h latency=%0d", res, lat);
  endtask

  task automatic test_roundtrip(input int n);
    logic [127:0] pt, k, ct, res;
    int lat;
    for (int i = 0; i < n; i++) begin
      pt = rand128();
      k  = rand128();
      model_encrypt(pt, k, ct);
      do_op(ct, k, res, lat);
      tests_run++;
      if (lat !== 21) begin tests_failed++; $display("FAIL rt_latency[%0d]: got %0d expected 21", i, lat); end
      tests_run++;
      if (res !== pt) begin tests_failed++; $display("FAIL rt_out[%0d]: got %h expected %h", i, res, pt); end
      $display("[TB] roundtrip %0d key=%h ct=%h out=%h", i, k, ct, res);
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] pt, k, ct, res;
    int dcount;
    pt = rand128();
    k  = rand128();
    model_encrypt(pt, k, ct);
    @(negedge clk);
    state = ct; key = k; start = 1'b1;
    @(posedge clk);
    dcount = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (done) dcount++;
      start = 1'($urandom_range(0, 1));
      state = rand128();
      key   = rand128();
    end
    @(negedge clk);
    start = 1'b0;
    if (done) dcount++;
    res = out;
    repeat (25) begin
      @(negedge clk);
      if (done) dcount++;
    end
    tests_run++;
    if (res !== pt) begin tests_failed++; $display("FAIL busy_out: got %h expected %h", res, pt); end
    tests_run++;
    if (dcount !== 1) begin tests_failed++; $display("FAIL busy_done_count: got %0d expected 1", dcount); end
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL busy_ready_after: got %b expected 1", ready); end
    $display("[TB] busy out=%h dones=%0d", res, dcount);
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat, dcount;
    launch(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f);
    repeat (15) @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", ready); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    tests_run++;
    if (out !== 128'h0) begin tests_failed++; $display("FAIL rstmid_out: got %h expected 0", out); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done: got %b expected 0", done); end
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcount++;
    end
    rst = 1'b0;
    state = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    key   = 128'h000102030405060708090a0b0c0d0e0f;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, res, lat);
    tests_run++;
    if (dcount !== 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d expected 0", dcount); end
    tests_run++;
    if (lat !== 21) begin tests_failed++; $display("FAIL rstmid_latency: got %0d expected 21", lat); end
    tests_run++;
    if (res !== 128'h00112233445566778899aabbccddeeff) begin
      tests_failed++; $display("FAIL rstmid_out_after: got %h expected 00112233445566778899aabbccddeeff", res);
    end
    $display("[TB] reset-mid recovery out=%h latency=%0d", res, lat);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt [3];
    logic [127:0] kk [3];
    logic [127:0] ct [3];
    int c, nd, last, set_at, extra;
    for (int b = 0; b < 3; b++) begin
      pt[b] = rand128();
      kk[b] = rand128();
      model_encrypt(pt[b], kk[b], ct[b]);
    end
    @(negedge clk);
    state = ct[0]; key = kk[0]; start = 1'b1;
    @(posedge clk);
    c = 0; nd = 0; last = 0; set_at = -1;
    while (nd < 3 && c < 100) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (c == 1) begin state = ct[1]; key = kk[1]; end
      if (c == set_at) begin
        if (nd == 1) begin state = ct[2]; key = kk[2]; end
        else start = 1'b0;
      end
      if (done) begin
        tests_run++;
        if (out !== pt[nd]) begin tests_failed++; $display("FAIL b2b_out[%0d]: got %h expected %h", nd, out, pt[nd]); end
        tests_run++;
        if (c - last !== ((nd == 0) ? 21 : 22)) begin
          tests_failed++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", nd, c - last, (nd == 0) ? 21 : 22);
        end
        $display("[TB] back-to-back block %0d at cycle %0d out=%h", nd, c, out);
        last = c;
        nd++;
        set_at = c + 1;
      end
    end
    start = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests_run++;
    if (nd !== 3) begin tests_failed++; $display("FAIL b2b_blocks: got %0d expected 3", nd); end
    tests_run++;
    if (extra !== 0) begin tests_failed++; $display("FAIL b2b_extra_done: got %0d expected 0", extra); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    start = 1'b0;
    state = '0;
    key   = '0;
    build_tables();
    test_reset();
    test_kat_c1();
    test_kat_b();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_roundtrip(1000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/aes_128_dec.md
AES_128_DEC -- requirements
Module: aes_128_dec

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock, with all flops on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-high.
REQ-004 The port start SHALL be an input, 1 bit wide: request to decrypt; it is sampled only while ready=1.
REQ-005 The port state SHALL be an input, 128 bits wide: ciphertext block, captured on the accepting edge.
REQ-006 The port key SHALL be an input, 128 bits wide: AES-128 cipher key (round key 0), captured on the accepting edge.
REQ-007 The port ready SHALL be an output, 1 bit wide: idle, so start will be accepted.
REQ-008 The port done SHALL be an output, 1 bit wide: one-cycle pulse marking out as valid.
REQ-009 The port out SHALL be an output, 128 bits wide: recovered plaintext, registered.

Function
REQ-010 The block SHALL implement the FIPS-197 AES-128 inverse cipher, one round per cycle, iteratively; it SHALL not be pipelined.
REQ-011 The FSM SHALL have the states IDLE, KEXP, INIT, ROUND, FINAL.
REQ-012 In IDLE, ready=1; a rising edge with start=1 SHALL capture state and key, load the round-key register with key, clear the round counter, and go to KEXP.
REQ-013 In KEXP, each edge SHALL apply the forward key-schedule step (RotWord, SubWord through the existing S4 S-box, rcon 01,02,04,08,10,20,40,80,1b,36); after 10 edges it SHALL hold round key 10 and go to INIT.
REQ-014 In INIT (1 edge), the state register SHALL become ciphertext XOR rk10, rk SHALL step back to rk9 via the inverse key-schedule step, and the FSM SHALL go to ROUND.
REQ-015 Inverse key step: w0'=w0^SubWord(RotWord(w3'))^rcon, where w3'=w3^w2, w2'=w2^w1, w1'=w1^w0; rcon SHALL be consumed in reverse order 36..01.
REQ-016 In ROUND (9 edges, rounds 9..1), state SHALL become InvMixColumns(InvSubBytes(InvShiftRows(s)) XOR rk), and rk SHALL step back once per edge.
REQ-017 In FINAL (1 edge), out SHALL become InvSubBytes(InvShiftRows(s)) XOR rk0, done SHALL go to 1 for exactly the next cycle, and the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be fixed: done=1 in the cycle after the 21st rising edge following the accepting edge (10 KEXP + 1 INIT + 9 ROUND + 1 FINAL).
REQ-019 ready SHALL be 0 from the accepting edge until the FINAL edge inclusive; ready SHALL be 1 in the same cycle that done=1.
REQ-020 start SHALL be ignored while ready=0; no request is queued.
REQ-021 start held high continuously SHALL start a new operation on the edge where done=1 and ready=1, giving back-to-back blocks every 22 cycles.
REQ-022 Changes on state/key after the accepting edge SHALL NOT affect the result.
REQ-023 out SHALL hold its last value until the next FINAL edge or reset.
REQ-024 InvSubBytes SHALL use 16 instances of a new combinational 256-entry inverse S-box submodule.
REQ-025 InvMixColumns SHALL use GF(2^8) multiplication by 0e, 0b, 0d, 09 with reduction polynomial 0x11b.

Reset
REQ-026 Asserting rst at any time, including mid-operation, SHALL immediately force: FSM=IDLE, ready=1, done=0, out=0, round counter=0, state and rk registers=0.
REQ-027 An operation interrupted by rst SHALL be abandoned, with no done pulse.
REQ-028 On the first rising edge after rst deasserts, start SHALL be accepted normally.

Verification
REQ-029 FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, state=69c4e0d86a7b0430d8cdb78070b4c55a -> out=00112233445566778899aabbccddeeff, with done at accept+21.
REQ-030 FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, state=3925841d02dc09fbdc118597196a0b32 -> out=3243f6a8885a308d313198a2e0370734; internal rk after KEXP=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 Round-trip: 1000 random key/plaintext pairs encrypted by aes_128, then decrypted -> out equals the plaintext every time.
REQ-032 start pulses on busy cycles, plus state/key toggled mid-operation -> result unchanged, exactly one done per accepted start.
REQ-033 rst asserted at the 5th ROUND edge -> outputs 0 and ready=1 immediately, no done; the next C.1 request is correct.
REQ-034 start held high for 3 blocks -> done pulses spaced exactly 22 cycles apart with correct outputs.
